// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: memory op encodings,
// op classification helpers and default widths / IO address.
package load_store_queue_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          ROB_W_DEF   = 3;
    localparam int          OP_W_DEF    = 6;
    localparam int unsigned IO_ADDR_DEF = 32'h30000;

    typedef enum logic [5:0] {
        OP_LB  = 6'd0,
        OP_LH  = 6'd1,
        OP_LW  = 6'd2,
        OP_LBU = 6'd4,
        OP_LHU = 6'd5,
        OP_SB  = 6'd8,
        OP_SH  = 6'd9,
        OP_SW  = 6'd10
    } mem_op_e;

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Memory request port of the load/store queue (valid/ready).
//   master: queue side, drives the request fields and valid
//   slave : memory controller side, drives ready
interface load_store_queue_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 3,
    parameter int OP_W  = 6
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_store;
    logic [OP_W-1:0]  mem_req_op;
    logic [XLEN-1:0]  mem_req_addr;
    logic [XLEN-1:0]  mem_req_wdata;
    logic [ROB_W-1:0] mem_req_rob_id;

    modport master (
        output mem_req_valid, mem_req_store, mem_req_op, mem_req_addr,
               mem_req_wdata, mem_req_rob_id,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_store, mem_req_op, mem_req_addr,
               mem_req_wdata, mem_req_rob_id,
        output mem_req_ready
    );
endinterface

// File: rtl/lsq_cdb_match.sv
// Combinational tag compare against all result broadcast channels.
//   tag       : tag being waited on
//   cdb_*     : packed broadcast channels, channel 0 in the LSBs
//   hit/data  : match found and the result of the lowest matching channel
module lsq_cdb_match #(
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 3,
    parameter int XLEN    = 32
) (
    input  logic [ROB_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);
    // Scan from the highest channel down so the lowest index overrides.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == tag) begin
                hit  = 1'b1;
                data = cdb_data[i*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch and the memory controller.
//   clk/rst/rdy        : clock, sync active-high reset, global enable
//   flush/stall        : mispredict flush, dispatch hold-off
//   disp_*             : dispatch of one load/store with operands or tags
//   cdb_*              : NUM_CDB result broadcast channels
//   commit_*           : ROB store commit
//   io_full            : blocks loads to IO_ADDR
//   mem                : registered memory request port (master)
//   head_*/full/empty/count : queue status
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          XLEN    = XLEN_DEF,
    parameter int          ROB_W   = ROB_W_DEF,
    parameter int          OP_W    = OP_W_DEF,
    parameter int          NUM_CDB = 2,
    parameter int unsigned IO_ADDR = IO_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       disp_valid,
    input  logic                       disp_is_store,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [ROB_W-1:0]           disp_rob_id,
    input  logic                       disp_base_rdy,
    input  logic [XLEN-1:0]            disp_base_val,
    input  logic [ROB_W-1:0]           disp_base_tag,
    input  logic [XLEN-1:0]            disp_imm,
    input  logic                       disp_data_rdy,
    input  logic [XLEN-1:0]            disp_data_val,
    input  logic [ROB_W-1:0]           disp_data_tag,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    input  logic                       commit_store,
    input  logic [ROB_W-1:0]           commit_rob_id,
    input  logic                       io_full,
    load_store_queue_if.master         mem,
    output logic                       head_store_ready,
    output logic [ROB_W-1:0]           head_rob_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head, tail;

    logic [DEPTH-1:0] e_valid, e_store, e_addr_rdy, e_data_rdy, e_comm, e_issued;
    logic [OP_W-1:0]  e_op       [DEPTH];
    logic [ROB_W-1:0] e_rob      [DEPTH];
    logic [ROB_W-1:0] e_base_tag [DEPTH];
    logic [ROB_W-1:0] e_data_tag [DEPTH];
    logic [XLEN-1:0]  e_addr     [DEPTH];
    logic [XLEN-1:0]  e_data     [DEPTH];

    logic [DEPTH-1:0] base_hit, data_hit;
    logic [XLEN-1:0]  base_cdb [DEPTH];
    logic [XLEN-1:0]  data_cdb [DEPTH];

    logic             d_base_hit, d_data_hit;
    logic [XLEN-1:0]  d_base_cdb, d_data_cdb;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_base (
            .tag(e_base_tag[i]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .hit(base_hit[i]), .data(base_cdb[i]));
        lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_data (
            .tag(e_data_tag[i]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .hit(data_hit[i]), .data(data_cdb[i]));
    end

    lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_disp_base (
        .tag(disp_base_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .hit(d_base_hit), .data(d_base_cdb));
    lsq_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_disp_data (
        .tag(disp_data_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .hit(d_data_hit), .data(d_data_cdb));

    assign full             = (count == CNT_W'(DEPTH));
    assign empty            = (count == '0);
    assign head_rob_id      = e_rob[head];
    assign head_store_ready = e_valid[head] && e_store[head] &&
                              e_addr_rdy[head] && e_data_rdy[head];

    logic             disp_fire, deq, issue, load_ok, store_ok, d_data_ok;
    logic [XLEN-1:0]  disp_addr;
    logic [CNT_W-1:0] n_comm, flush_len;

    always_comb begin
        disp_fire = disp_valid && !stall && !flush && !full;
        deq       = mem.mem_req_valid && mem.mem_req_ready;
        load_ok   = e_addr_rdy[head] && !(e_addr[head] == XLEN'(IO_ADDR) && io_full);
        store_ok  = e_comm[head] && e_addr_rdy[head] && e_data_rdy[head];
        // A load must not be launched in the cycle that discards it.
        issue     = e_valid[head] && !e_issued[head] && !mem.mem_req_valid &&
                    (e_store[head] ? store_ok : (load_ok && !flush));

        // Unready base: keep only imm, the CDB result is added on capture.
        disp_addr = disp_imm + (disp_base_rdy ? disp_base_val :
                                d_base_hit    ? d_base_cdb    : '0);
        d_data_ok = !disp_is_store || disp_data_rdy || d_data_hit;

        n_comm = '0;
        for (int i = 0; i < DEPTH; i++)
            n_comm = n_comm + CNT_W'(e_valid[i] && e_comm[i]);
        // A load accepted in the flush cycle still has to leave through head,
        // so keep it in the span that survives.
        flush_len = n_comm + CNT_W'(deq && !e_comm[head]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            e_valid            <= '0;
            e_store            <= '0;
            e_addr_rdy         <= '0;
            e_data_rdy         <= '0;
            e_comm             <= '0;
            e_issued           <= '0;
            mem.mem_req_valid  <= 1'b0;
            mem.mem_req_store  <= 1'b0;
            mem.mem_req_op     <= '0;
            mem.mem_req_addr   <= '0;
            mem.mem_req_wdata  <= '0;
            mem.mem_req_rob_id <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && !e_addr_rdy[i] && base_hit[i]) begin
                    e_addr[i]     <= e_addr[i] + base_cdb[i];
                    e_addr_rdy[i] <= 1'b1;
                end
                if (e_valid[i] && !e_data_rdy[i] && data_hit[i]) begin
                    e_data[i]     <= data_cdb[i];
                    e_data_rdy[i] <= 1'b1;
                end
                if (commit_store && !flush && e_valid[i] && e_store[i] &&
                    e_rob[i] == commit_rob_id)
                    e_comm[i] <= 1'b1;
            end

            if (issue) begin
                e_issued[head]     <= 1'b1;
                mem.mem_req_valid  <= 1'b1;
                mem.mem_req_store  <= e_store[head];
                mem.mem_req_op     <= e_op[head];
                mem.mem_req_addr   <= e_addr[head];
                mem.mem_req_wdata  <= e_data[head];
                mem.mem_req_rob_id <= e_rob[head];
            end else if (deq) begin
                mem.mem_req_valid  <= 1'b0;
            end

            if (deq)
                e_valid[head] <= 1'b0;

            if (flush) begin
                if (mem.mem_req_valid && !mem.mem_req_ready && !mem.mem_req_store)
                    mem.mem_req_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++)
                    if (!e_comm[i])
                        e_valid[i] <= 1'b0;
                tail  <= head + PTR_W'(flush_len);
                head  <= head + PTR_W'(deq);
                count <= flush_len - CNT_W'(deq);
            end else begin
                if (disp_fire) begin
                    e_valid[tail]    <= 1'b1;
                    e_store[tail]    <= disp_is_store;
                    e_op[tail]       <= disp_op;
                    e_rob[tail]      <= disp_rob_id;
                    e_comm[tail]     <= 1'b0;
                    e_issued[tail]   <= 1'b0;
                    e_addr_rdy[tail] <= disp_base_rdy || d_base_hit;
                    e_addr[tail]     <= disp_addr;
                    e_base_tag[tail] <= disp_base_tag;
                    e_data_rdy[tail] <= d_data_ok;
                    e_data[tail]     <= !disp_is_store ? '0 :
                                        disp_data_rdy  ? disp_data_val : d_data_cdb;
                    e_data_tag[tail] <= disp_data_tag;
                end
                tail  <= tail + PTR_W'(disp_fire);
                head  <= head + PTR_W'(deq);
                count <= count + CNT_W'(disp_fire) - CNT_W'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && disp_valid && !stall && !flush)
            assert (!full) else $warning("load_store_queue: dispatch dropped while queue full");
    end

endmodule
